// File: rtl/cube_pkg.sv
// ============================================================================
//  Module      : cube_pkg
//  Description : Shared constants for the 8x8x8 LED cube frame scheduler:
//                cube geometry, vector widths and the step-handshake state
//                encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cube_pkg;

    localparam int CUBE_N      = 8;
    localparam int CELL_BITS   = CUBE_N * CUBE_N * CUBE_N;   // 512
    localparam int LAYER_BITS  = CUBE_N * CUBE_N;            // 64
    localparam int LAYER_SEL_W = $clog2(CUBE_N);             // 3

    // Step handshake FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/cube_scan_timer.sv
// ============================================================================
//  Module      : cube_scan_timer
//  Description : Layer scan timebase. Steps through the cube one layer per
//                LAYER_CYCLES slot, blanking the drive for the first
//                BLANK_CYCLES of each slot.
//  Ports       : clk, rst_n       - clock, async active-low reset
//                layer_sel        - registered current layer
//                layer_nxt        - value layer_sel takes at the next edge
//                layer_en         - drive enable (low during blanking)
//                frame_start      - pulse on first cycle of layer 0
//                frame_tick       - high in the last cycle of a frame, so the
//                                   next edge is the frame boundary
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cube_scan_timer
    import cube_pkg::*;
#(
    parameter int LAYER_CYCLES = 6250,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [LAYER_SEL_W-1:0] layer_sel,
    output logic [LAYER_SEL_W-1:0] layer_nxt,
    output logic                   layer_en,
    output logic                   frame_start,
    output logic                   frame_tick
);

    localparam int SLOT_W = (LAYER_CYCLES > 1) ? $clog2(LAYER_CYCLES) : 1;
    localparam logic [SLOT_W-1:0]      SLOT_LAST  = SLOT_W'(LAYER_CYCLES - 1);
    localparam logic [SLOT_W-1:0]      BLANK_END  = SLOT_W'(BLANK_CYCLES);
    localparam logic [LAYER_SEL_W-1:0] LAYER_LAST = LAYER_SEL_W'(CUBE_N - 1);

    logic [SLOT_W-1:0] slot_cnt;
    logic              slot_wrap;

    assign slot_wrap  = (slot_cnt == SLOT_LAST);
    assign frame_tick = slot_wrap && (layer_sel == LAYER_LAST);
    // CUBE_N is a power of two, so the increment wraps 7 -> 0 on its own.
    assign layer_nxt  = slot_wrap ? layer_sel + LAYER_SEL_W'(1) : layer_sel;
    assign layer_en   = (slot_cnt >= BLANK_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt    <= '0;
            layer_sel   <= '0;
            frame_start <= 1'b0;
        end else begin
            slot_cnt    <= slot_wrap ? '0 : slot_cnt + SLOT_W'(1);
            layer_sel   <= layer_nxt;
            frame_start <= frame_tick;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cube_frame_sched.sv
// ============================================================================
//  Module      : cube_frame_sched
//  Description : Scheduler between the Life simulator and the cube drive
//                path. Owns the frame buffer, scans it out layer by layer,
//                paces simulator generations through a req/ack handshake
//                and only snapshots the simulator state at frame boundaries
//                while the simulator is idle (no torn generations).
//  Ports       : Clk, Reset(active-low async)
//                Run, StepBtn, SpeedSel  - pacing controls
//                StepReq / StepAck       - simulator handshake
//                CellsIn                 - live simulator state (z*64+y*8+x)
//                LayerSel, LayerData,
//                LayerEn, FrameStart     - cube drive interface
//                GenCount                - completed generations (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cube_frame_sched
    import cube_pkg::*;
#(
    parameter int LAYER_CYCLES = 6250,
    parameter int BLANK_CYCLES = 64,
    parameter int BASE_FRAMES  = 125,
    parameter int GEN_W        = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Run,
    input  logic                   StepBtn,
    input  logic [1:0]             SpeedSel,
    input  logic                   StepAck,
    input  logic [CELL_BITS-1:0]   CellsIn,
    output logic                   StepReq,
    output logic [LAYER_SEL_W-1:0] LayerSel,
    output logic [LAYER_BITS-1:0]  LayerData,
    output logic                   LayerEn,
    output logic                   FrameStart,
    output logic [GEN_W-1:0]       GenCount
);

    // Large enough to hold BASE_FRAMES << 3 without wrapping.
    localparam int FC_W = $clog2(BASE_FRAMES * 8 + 1);

    logic [LAYER_SEL_W-1:0] layer_nxt;
    logic                   frame_tick;
    logic [1:0]             state;
    logic                   pend;
    logic [FC_W-1:0]        frame_cnt;
    logic [FC_W-1:0]        frame_last;
    logic                   run_fire;
    logic                   snap;
    logic [CELL_BITS-1:0]   frame;
    logic [CELL_BITS-1:0]   frame_nxt;

    cube_scan_timer #(
        .LAYER_CYCLES (LAYER_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_scan (
        .clk         (Clk),
        .rst_n       (Reset),
        .layer_sel   (LayerSel),
        .layer_nxt   (layer_nxt),
        .layer_en    (LayerEn),
        .frame_start (FrameStart),
        .frame_tick  (frame_tick)
    );

    // SpeedSel is sampled live, so a change applies at the next compare.
    assign frame_last = (FC_W'(BASE_FRAMES) << SpeedSel) - FC_W'(1);
    assign run_fire   = Run && frame_tick && (frame_cnt == frame_last);

    // StepAck high in IDLE means the sim may still be writing; skip the copy.
    assign snap      = frame_tick && (state == ST_IDLE) && !StepAck;
    assign frame_nxt = snap ? CellsIn : frame;

    // Frame buffer and scan-out. LayerData is registered from the next-state
    // frame/layer so it moves on the same edge as LayerSel, including the
    // boundary edge where a fresh snapshot is taken.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            frame     <= '0;
            LayerData <= '0;
        end else begin
            frame     <= frame_nxt;
            LayerData <= frame_nxt[layer_nxt*LAYER_BITS +: LAYER_BITS];
        end
    end

    // RUN pacing counter: counts frame boundaries while Run is high. It
    // clears on a fire even when the fire is dropped because a step is busy.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            frame_cnt <= '0;
        end else if (!Run) begin
            frame_cnt <= '0;
        end else if (frame_tick) begin
            frame_cnt <= (frame_cnt == frame_last) ? '0 : frame_cnt + FC_W'(1);
        end
    end

    // Step handshake. A StepBtn seen while busy is remembered once (pend);
    // RUN fires while busy are simply lost.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            StepReq  <= 1'b0;
            pend     <= 1'b0;
            GenCount <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (StepBtn || run_fire || pend) begin
                        state   <= ST_REQ;
                        StepReq <= 1'b1;
                        pend    <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (StepBtn) begin
                        pend <= 1'b1;
                    end
                    if (StepAck) begin
                        state    <= ST_DONE;
                        StepReq  <= 1'b0;
                        GenCount <= GenCount + GEN_W'(1);
                    end
                end
                ST_DONE: begin
                    if (StepBtn) begin
                        pend <= 1'b1;
                    end
                    if (!StepAck) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    StepReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cube_frame_sched.sv
// ============================================================================
//  Module      : tb_cube_frame_sched
//  Description : Self-checking bench for cube_frame_sched with a small
//                behavioural model (time-based scan arithmetic plus a
//                handshake model) and an automatic simulator responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cube_frame_sched;

    localparam int LC    = 8;
    localparam int BC    = 2;
    localparam int BF    = 2;
    localparam int GW    = 4;
    localparam int FRAME = LC * 8;
    localparam int VW    = 1 + 3 + 64 + 1 + 1 + GW;

    logic           Clk      = 1'b0;
    logic           Reset    = 1'b0;
    logic           Run      = 1'b0;
    logic           StepBtn  = 1'b0;
    logic [1:0]     SpeedSel = 2'd0;
    logic           StepAck  = 1'b0;
    logic [511:0]   CellsIn  = '0;
    logic           StepReq;
    logic [2:0]     LayerSel;
    logic [63:0]    LayerData;
    logic           LayerEn;
    logic           FrameStart;
    logic [GW-1:0]  GenCount;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    cube_frame_sched #(
        .LAYER_CYCLES (LC),
        .BLANK_CYCLES (BC),
        .BASE_FRAMES  (BF),
        .GEN_W        (GW)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Run        (Run),
        .StepBtn    (StepBtn),
        .SpeedSel   (SpeedSel),
        .StepAck    (StepAck),
        .CellsIn    (CellsIn),
        .StepReq    (StepReq),
        .LayerSel   (LayerSel),
        .LayerData  (LayerData),
        .LayerEn    (LayerEn),
        .FrameStart (FrameStart),
        .GenCount   (GenCount)
    );

    // ---------------- simulator responder ----------------
    bit auto_ack  = 1'b0;
    bit force_ack = 1'b0;
    int ack_delay = 3;
    int ack_hold  = 1;
    int ack_cnt   = 0;

    always @(negedge Clk) begin
        if (!Reset) begin
            StepAck = 1'b0;
            ack_cnt = 0;
        end else if (force_ack) begin
            StepAck = 1'b1;
            ack_cnt = 0;
        end else if (!auto_ack) begin
            StepAck = 1'b0;
            ack_cnt = 0;
        end else if (!StepAck) begin
            if (StepReq) begin
                ack_cnt++;
                if (ack_cnt >= ack_delay) begin
                    StepAck = 1'b1;
                    ack_cnt = 0;
                end
            end else begin
                ack_cnt = 0;
            end
        end else begin
            ack_cnt++;
            if (ack_cnt >= ack_hold && !StepReq) begin
                StepAck = 1'b0;
                ack_cnt = 0;
            end
        end
    end

    // ---------------- reference model ----------------
    // Scan position is pure arithmetic on the cycle count since reset.
    int           m_cyc   = 0;
    logic [511:0] m_frame = '0;
    int           m_phase = 0;   // 0 sim idle, 1 request out, 2 acked
    bit           m_pend  = 1'b0;
    int           m_gen   = 0;
    int           m_fc    = 0;
    bit           m_bound;
    bit           m_fire;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_cyc = 0; m_frame = '0; m_phase = 0; m_pend = 1'b0; m_gen = 0; m_fc = 0;
        end else begin
            m_bound = (m_cyc % FRAME) == FRAME - 1;
            m_fire  = Run && m_bound && (m_fc == (BF << SpeedSel) - 1);
            if (m_bound && m_phase == 0 && !StepAck) m_frame = CellsIn;
            if (!Run)         m_fc = 0;
            else if (m_bound) m_fc = m_fire ? 0 : m_fc + 1;
            case (m_phase)
                0: if (StepBtn || m_fire || m_pend) begin m_phase = 1; m_pend = 1'b0; end
                1: begin
                    if (StepBtn) m_pend = 1'b1;
                    if (StepAck) begin m_phase = 2; m_gen = (m_gen + 1) % (1 << GW); end
                end
                default: begin
                    if (StepBtn) m_pend = 1'b1;
                    if (!StepAck) m_phase = 0;
                end
            endcase
            m_cyc++;
        end
    end

    function automatic logic [VW-1:0] exp_vec();
        int slot;
        int lay;
        logic [63:0] d;
        slot = m_cyc % LC;
        lay  = (m_cyc / LC) % 8;
        d    = m_frame[lay*64 +: 64];
        return {(m_phase == 1), 3'(lay), d, (slot >= BC),
                (m_cyc > 0 && (m_cyc % FRAME) == 0), GW'(m_gen)};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {StepReq, LayerSel, LayerData, LayerEn, FrameStart, GenCount};
    endfunction

    function automatic logic [511:0] rand_cells();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [511:0] pat;
        int lay;
        for (int z = 0; z < 8; z++) pat[z*64 +: 64] = {8{8'hA5 ^ 8'(z)}};
        Reset = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            total++;
            if (obs_vec() !== '0) begin
                bad++;
                $display("FAIL reset_outputs: got=%h want=0", obs_vec());
            end
        end
        CellsIn = pat;
        Reset   = 1'b1;
        for (int k = 1; k <= 3 * FRAME; k++) begin
            @(negedge Clk);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL scan: got=%h want=%h cyc=%0d", obs_vec(), exp_vec(), m_cyc);
            end
            if (k >= FRAME) begin
                lay = (k / LC) % 8;
                total++;
                if (LayerData !== pat[lay*64 +: 64]) begin
                    bad++;
                    $display("FAIL scan_slice: got=%h want=%h k=%0d", LayerData, pat[lay*64 +: 64], k);
                end
            end
        end
    endtask

    task automatic test_run();
        auto_ack = 1'b1; ack_delay = 3; ack_hold = 1;
        Run = 1'b1; SpeedSel = 2'd0;
        for (int k = 0; k < 5 * FRAME + 18 * FRAME; k++) begin
            @(negedge Clk);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL run_pacing: got=%h want=%h cyc=%0d", obs_vec(), exp_vec(), m_cyc);
            end
            if (k == 5 * FRAME) SpeedSel = 2'd2;
            if ((k % FRAME) == 17) CellsIn = rand_cells();
        end
        Run = 1'b0; SpeedSel = 2'd0;
    endtask

    task automatic test_step();
        int g0;
        auto_ack = 1'b1; ack_delay = 1; ack_hold = 5;
        repeat (10) @(negedge Clk);
        g0 = m_gen;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL single_step: got=%h want=%h i=%0d", obs_vec(), exp_vec(), i);
            end
            StepBtn = (i == 0 || i == 3 || i == 5);
        end
        StepBtn = 1'b0;
        total++;
        if (GenCount !== GW'(g0 + 2)) begin
            bad++;
            $display("FAIL step_pend_count: got=%0d want=%0d", GenCount, GW'(g0 + 2));
        end
    endtask

    task automatic test_snapshot_hold();
        logic [511:0] a;
        logic [511:0] b;
        int lay;
        int w;
        bit found;
        auto_ack = 1'b1; ack_delay = 1; ack_hold = 1;
        a = rand_cells(); b = rand_cells();
        CellsIn = a;
        found = 1'b0;
        w = 0;
        while (!found && w < 3 * FRAME) begin
            @(negedge Clk);
            w++;
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL snap_pre: got=%h want=%h", obs_vec(), exp_vec());
            end
            if (w > FRAME && (m_cyc % FRAME) == FRAME - 8) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL snap_align_timeout: got=0 want=1");
        end
        force_ack = 1'b1;
        CellsIn   = b;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge Clk);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL snap_hold: got=%h want=%h", obs_vec(), exp_vec());
            end
        end
        lay = (m_cyc / LC) % 8;
        total++;
        if (LayerData !== a[lay*64 +: 64]) begin
            bad++;
            $display("FAIL snap_suppressed: got=%h want=%h", LayerData, a[lay*64 +: 64]);
        end
        force_ack = 1'b0;
        for (int k = 0; k < FRAME + 8; k++) begin
            @(negedge Clk);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL snap_release: got=%h want=%h", obs_vec(), exp_vec());
            end
        end
        lay = (m_cyc / LC) % 8;
        total++;
        if (LayerData !== b[lay*64 +: 64]) begin
            bad++;
            $display("FAIL snap_reload: got=%h want=%h", LayerData, b[lay*64 +: 64]);
        end
    endtask

    task automatic test_coincident();
        int g0;
        int rises;
        bit hit;
        bit prev_req;
        auto_ack = 1'b1; ack_delay = 2; ack_hold = 1;
        Run = 1'b1; SpeedSel = 2'd0;
        hit = 1'b0; g0 = 0;
        for (int k = 0; k < 10 * FRAME && !hit; k++) begin
            @(negedge Clk);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL coinc_pre: got=%h want=%h", obs_vec(), exp_vec());
            end
            if ((m_cyc % FRAME) == FRAME - 1 && m_fc == BF - 1 && m_phase == 0 && !StepAck) begin
                StepBtn = 1'b1;
                g0 = m_gen;
                hit = 1'b1;
            end
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL coinc_timeout: got=0 want=1");
        end
        rises = 0;
        prev_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            StepBtn = 1'b0;
            if (StepReq && !prev_req) rises++;
            prev_req = StepReq;
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL coinc: got=%h want=%h", obs_vec(), exp_vec());
            end
        end
        Run = 1'b0;
        total++;
        if (rises != 1 || GenCount !== GW'(g0 + 1)) begin
            bad++;
            $display("FAIL coinc_one_step: got rises=%0d gen=%0d want rises=1 gen=%0d",
                     rises, GenCount, GW'(g0 + 1));
        end
    endtask

    task automatic test_random();
        auto_ack = 1'b1;
        Run = 1'b1; SpeedSel = 2'd0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge Clk);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random: got=%h want=%h cyc=%0d", obs_vec(), exp_vec(), m_cyc);
            end
            StepBtn   = ($urandom_range(0, 9) == 0);
            ack_delay = $urandom_range(1, 4);
            ack_hold  = $urandom_range(1, 6);
            if ($urandom_range(0, 199) == 0) Run = ~Run;
            if ($urandom_range(0, 299) == 0) SpeedSel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0)  CellsIn = rand_cells();
            if ($urandom_range(0, 149) == 0) force_ack = 1'b1;
            else if (force_ack && $urandom_range(0, 7) == 0) force_ack = 1'b0;
        end
        StepBtn = 1'b0; force_ack = 1'b0; Run = 1'b0; SpeedSel = 2'd0;
        for (int k = 0; k < 30; k++) begin
            @(negedge Clk);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random_drain: got=%h want=%h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        auto_ack = 1'b0;
        @(negedge Clk);
        StepBtn = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge Clk);
            StepBtn = 1'b0;
            if (StepReq) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL rst_mid_req_timeout: got=0 want=1");
        end
        #2 Reset = 1'b0;
        #1;
        total++;
        if ({StepReq, LayerEn, LayerData} !== '0) begin
            bad++;
            $display("FAIL rst_mid_async: got req=%b en=%b data=%h want all 0", StepReq, LayerEn, LayerData);
        end
        @(negedge Clk);
        @(negedge Clk);
        total++;
        if (GenCount !== '0 || LayerSel !== 3'd0 || FrameStart !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_hold: got gen=%0d sel=%0d fs=%b want 0", GenCount, LayerSel, FrameStart);
        end
        Reset = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge Clk);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL rst_mid_restart: got=%h want=%h", obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_step();
        test_snapshot_hold();
        test_coincident();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
